// File: rtl/pixel_pkg.sv
// Shared types for the pixel frame feeder: FSM states, per-pixel marker flags
// and the completed-frame counter width.
package pixel_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        BLANK   = 2'd2,
        DONE    = 2'd3
    } t_feeder_states;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } t_pixel_flags;

endpackage

// File: rtl/pixel_raster_counter.sv
// Raster position tracker: x/y counters advanced once per accepted pixel, with
// end-of-line / last-line compares against the latched (size-1) values.
module pixel_raster_counter #(
    parameter int SIZE_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_adv,
    input  logic [SIZE_W-1:0] i_last_x_idx,
    input  logic [SIZE_W-1:0] i_last_y_idx,
    output logic [SIZE_W-1:0] o_x,
    output logic [SIZE_W-1:0] o_y,
    output logic              o_last_x,
    output logic              o_last_y
);

    logic [SIZE_W-1:0] r_x;
    logic [SIZE_W-1:0] r_y;
    logic              w_last_x;
    logic              w_last_y;

    // Compare against size-1 so a full 2^SIZE_W-1 dimension never overflows.
    assign w_last_x = (r_x == i_last_x_idx);
    assign w_last_y = (r_y == i_last_y_idx);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_adv) begin
            if (w_last_x) begin
                r_x <= '0;
                r_y <= w_last_y ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_last_x = w_last_x;
    assign o_last_y = w_last_y;

endmodule

// File: rtl/pixel_frame_feeder.sv
// Streams one raster frame from a source handshake to a DUT handshake with
// horizontal blanking, sof/eol/eof markers, abort and a completion pulse.
//
// state   | meaning
// IDLE    | waiting for start; done pulses here for one cycle after a frame
// RUNNING | accepting source pixels into the output register
// BLANK   | hblank idle cycles after a non-final line, source held off
// DONE    | last pixel accepted, waiting for it to drain downstream
module pixel_frame_feeder
    import pixel_pkg::*;
#(
    parameter int PIXEL_W  = 8,
    parameter int CHANNELS = 3,
    parameter int SIZE_W   = 12,
    parameter int BLANK_W  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic [SIZE_W-1:0]           i_size_x,
    input  logic [SIZE_W-1:0]           i_size_y,
    input  logic [BLANK_W-1:0]          i_hblank,
    input  logic [PIXEL_W*CHANNELS-1:0] i_src_pixel,
    input  logic                        i_src_valid,
    output logic                        o_src_ready,
    output logic [PIXEL_W*CHANNELS-1:0] o_pixel_out,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic                        o_sof,
    output logic                        o_eol,
    output logic                        o_eof,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [FRAME_CNT_W-1:0]      o_frame_count
);

    localparam int DW = PIXEL_W * CHANNELS;

    t_feeder_states          r_state;
    logic [SIZE_W-1:0]       r_last_x_idx;
    logic [SIZE_W-1:0]       r_last_y_idx;
    logic [BLANK_W-1:0]      r_hblank;
    logic [BLANK_W-1:0]      r_blank_cnt;
    logic                    r_out_valid;
    logic [DW-1:0]           r_pixel;
    t_pixel_flags            r_flags;
    logic                    r_done;
    logic [FRAME_CNT_W-1:0]  r_frame_count;

    logic                    w_src_ready;
    logic                    w_xfer;
    logic                    w_clr;
    logic                    w_adv;
    logic [SIZE_W-1:0]       w_x;
    logic [SIZE_W-1:0]       w_y;
    logic                    w_last_x;
    logic                    w_last_y;

    // Source is throttled combinationally so out_ready=0 stalls it in the same cycle.
    assign w_src_ready = (r_state == RUNNING) && (!r_out_valid || i_out_ready);
    assign w_xfer      = i_src_valid && w_src_ready;
    assign w_clr       = i_abort || ((r_state == IDLE) && i_start);
    assign w_adv       = w_xfer && !i_abort;

    pixel_raster_counter #(
        .SIZE_W (SIZE_W)
    ) u_raster (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_clr        (w_clr),
        .i_adv        (w_adv),
        .i_last_x_idx (r_last_x_idx),
        .i_last_y_idx (r_last_y_idx),
        .o_x          (w_x),
        .o_y          (w_y),
        .o_last_x     (w_last_x),
        .o_last_y     (w_last_y)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_last_x_idx  <= '0;
            r_last_y_idx  <= '0;
            r_hblank      <= '0;
            r_blank_cnt   <= '0;
            r_out_valid   <= 1'b0;
            r_pixel       <= '0;
            r_flags       <= '0;
            r_done        <= 1'b0;
            r_frame_count <= '0;
        end else if (i_abort) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_blank_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_pixel     <= i_src_pixel;
                r_flags.sof <= (w_x == '0) && (w_y == '0);
                r_flags.eol <= w_last_x;
                r_flags.eof <= w_last_x && w_last_y;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_last_x_idx <= i_size_x - 1'b1;
                        r_last_y_idx <= i_size_y - 1'b1;
                        r_hblank     <= i_hblank;
                        r_state      <= ((i_size_x == '0) || (i_size_y == '0)) ? DONE : RUNNING;
                    end
                end
                RUNNING: begin
                    if (w_xfer && w_last_x) begin
                        if (w_last_y) begin
                            r_state <= DONE;
                        end else if (r_hblank != '0) begin
                            r_state     <= BLANK;
                            r_blank_cnt <= r_hblank;
                        end
                    end
                end
                BLANK: begin
                    if (r_blank_cnt == BLANK_W'(1)) begin
                        r_state <= RUNNING;
                    end else begin
                        r_blank_cnt <= r_blank_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (!r_out_valid || i_out_ready) begin
                        r_state       <= IDLE;
                        r_done        <= 1'b1;
                        r_frame_count <= r_frame_count + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_src_ready   = w_src_ready;
    assign o_pixel_out   = r_pixel;
    assign o_out_valid   = r_out_valid;
    assign o_sof         = r_flags.sof;
    assign o_eol         = r_flags.eol;
    assign o_eof         = r_flags.eof;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = r_done;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_pixel_frame_feeder.sv
// Directed bench for pixel_frame_feeder: source counter model, output logger
// and hand-computed expectations for each frame scenario.
module tb_pixel_frame_feeder;

    localparam int DW = 24;
    localparam int SW = 12;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [SW-1:0] size_x = '0;
    logic [SW-1:0] size_y = '0;
    logic [BW-1:0] hblank = '0;
    logic [DW-1:0] src_pixel;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] pixel_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          sof, eol, eof, busy, done;
    logic [15:0]   frame_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] pix;
        logic          sof;
        logic          eol;
        logic          eof;
        int            c;
    } rec_t;

    rec_t          outq[$];
    int            srcc[$];
    logic [7:0]    src_idx = 8'd0;
    logic          src_hs = 1'b0;
    int            stall_err = 0;
    logic          stalled = 1'b0;
    logic [DW-1:0] stall_pix = '0;
    logic [2:0]    stall_fl = '0;

    function automatic logic [DW-1:0] pix(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {b, ~b, 8'h5A};
    endfunction

    assign src_pixel = pix(int'(src_idx));

    pixel_frame_feeder dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_abort       (abort),
        .i_size_x      (size_x),
        .i_size_y      (size_y),
        .i_hblank      (hblank),
        .i_src_pixel   (src_pixel),
        .i_src_valid   (src_valid),
        .o_src_ready   (src_ready),
        .o_pixel_out   (pixel_out),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_sof         (sof),
        .o_eol         (eol),
        .o_eof         (eof),
        .o_busy        (busy),
        .o_done        (done),
        .o_frame_count (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_hs) src_idx <= src_idx + 8'd1;
    end

    // Handshakes are decided at the falling edge, where all inputs are settled.
    always @(negedge clk) begin
        src_hs = src_valid && src_ready;
        if (src_hs) srcc.push_back(cyc);
        if (out_valid && out_ready)
            outq.push_back('{pix: pixel_out, sof: sof, eol: eol, eof: eof, c: cyc});
        if (stalled && !(out_valid && pixel_out == stall_pix && {sof, eol, eof} == stall_fl))
            stall_err++;
        stalled   = out_valid && !out_ready;
        stall_pix = pixel_out;
        stall_fl  = {sof, eol, eof};
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input int sx, input int sy, input int hb);
        @(posedge clk); #1;
        size_x = SW'(sx);
        size_y = SW'(sy);
        hblank = BW'(hb);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic run_until_done(input int max, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        int dcyc;
        int base;
        int n;
        int e;
        int done_seen;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_flags", {sof, eol, eof}, 0);
        chk("rst_frame_count", frame_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        src_valid = 1'b1;

        // 4x3, no blanking, full throughput
        @(negedge clk);
        outq.delete();
        srcc.delete();
        base = int'(src_idx);
        start_frame(4, 3, 0);
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_src_ready", src_ready, 1);
        chk("t1_no_early_valid", out_valid, 0);
        run_until_done(100, dcyc);
        chk("t1_count", outq.size(), 12);
        for (int k = 0; k < outq.size() && k < 12; k++) begin
            chk("t1_pix", outq[k].pix, pix(base + k));
            chk("t1_sof", outq[k].sof, (k == 0));
            chk("t1_eol", outq[k].eol, (k % 4 == 3));
            chk("t1_eof", outq[k].eof, (k == 11));
            chk("t1_consecutive", outq[k].c - outq[0].c, k);
        end
        if (outq.size() == 12) chk("t1_done_cycle", dcyc, outq[11].c + 1);
        chk("t1_frames", frame_count, 1);
        @(negedge clk);
        chk("t1_done_pulse_width", done, 0);
        chk("t1_idle", busy, 0);

        // 4x3 with hblank=2
        outq.delete();
        srcc.delete();
        start_frame(4, 3, 2);
        run_until_done(100, dcyc);
        chk("t2_src_count", srcc.size(), 12);
        if (srcc.size() == 12) begin
            chk("t2_line0_span", srcc[3] - srcc[0], 3);
            chk("t2_blank_after_px3", srcc[4] - srcc[3], 3);
            chk("t2_blank_after_px7", srcc[8] - srcc[7], 3);
            chk("t2_line2_span", srcc[11] - srcc[8], 3);
            chk("t2_total_span", srcc[11] - srcc[0], 15);
        end
        chk("t2_out_count", outq.size(), 12);
        if (outq.size() == 12) chk("t2_done_cycle", dcyc, outq[11].c + 1);
        chk("t2_frames", frame_count, 2);

        // 5x5 with random out_ready and source gaps
        outq.delete();
        base = int'(src_idx);
        stall_err = 0;
        start_frame(5, 5, 0);
        dcyc = -1;
        for (int i = 0; i < 600 && dcyc < 0; i++) begin
            @(negedge clk);
            if (done) dcyc = cyc;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 1) == 1);
            src_valid = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
        src_valid = 1'b1;
        chk("t3_finished", (dcyc >= 0), 1);
        chk("t3_count", outq.size(), 25);
        for (int k = 0; k < outq.size() && k < 25; k++) begin
            chk("t3_pix", outq[k].pix, pix(base + k));
            chk("t3_eol", outq[k].eol, (k % 5 == 4));
        end
        if (outq.size() == 25) chk("t3_eof_last", outq[24].eof, 1);
        chk("t3_stall_stable", stall_err, 0);
        chk("t3_frames", frame_count, 3);

        // Zero-size frame
        @(negedge clk);
        outq.delete();
        srcc.delete();
        start_frame(0, 3, 0);
        @(negedge clk);
        e = cyc;
        chk("t4_busy", busy, 1);
        chk("t4_no_valid", out_valid, 0);
        chk("t4_no_src_ready", src_ready, 0);
        run_until_done(20, dcyc);
        chk("t4_done_cycle", dcyc, e + 1);
        chk("t4_no_output", outq.size(), 0);
        chk("t4_no_source", srcc.size(), 0);
        chk("t4_frames", frame_count, 4);

        // Abort mid-frame, then a clean 2x2
        outq.delete();
        start_frame(8, 8, 0);
        n = 0;
        while (outq.size() < 6 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reached_px5", (outq.size() >= 6), 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_src_ready", src_ready, 0);
        done_seen = int'(done);
        repeat (6) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        chk("t5_no_done", done_seen, 0);
        chk("t5_frames_kept", frame_count, 4);
        outq.delete();
        base = int'(src_idx);
        start_frame(2, 2, 0);
        run_until_done(50, dcyc);
        chk("t5_next_count", outq.size(), 4);
        if (outq.size() == 4) begin
            chk("t5_next_sof", outq[0].sof, 1);
            chk("t5_next_pix0", outq[0].pix, pix(base));
            chk("t5_next_eol1", outq[1].eol, 1);
            chk("t5_next_eof3", outq[3].eof, 1);
        end
        chk("t5_frames", frame_count, 5);

        // Asynchronous reset mid-frame
        start_frame(4, 4, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_src_ready", src_ready, 0);
        chk("t6_pixel_out", pixel_out, 0);
        chk("t6_flags", {sof, eol, eof}, 0);
        chk("t6_frame_count", frame_count, 0);
        @(negedge clk);
        chk("t6_held_busy", busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        outq.delete();
        base = int'(src_idx);
        start_frame(2, 2, 0);
        run_until_done(50, dcyc);
        chk("t6_count", outq.size(), 4);
        if (outq.size() == 4) chk("t6_pix0", outq[0].pix, pix(base));
        chk("t6_frames", frame_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_frame_feeder.md
# pixel_frame_feeder

Synthesizable, parametrised successor of the bench-side pixel feeder: on `start` it streams one raster frame of `size_x * size_y` multi-channel pixels from a source port to the DUT input. It adds valid/ready backpressure on both sides, per-line horizontal blanking, start-of-frame, end-of-line and end-of-frame markers, abort, and a completion pulse. It sits between the pixel source (memory reader or bench model) and `dut_top.pixel_in`.

## Interface
- `PIXEL_W`, 8, bits per channel
- `CHANNELS`, 3, channels per pixel; data width `DW = PIXEL_W*CHANNELS`
- `SIZE_W`, 12, width of `size_x`/`size_y`
- `BLANK_W`, 8, width of `hblank`
- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: begin frame; sampled only in IDLE
- `abort` in 1: synchronous; kills the frame
- `size_x`, `size_y` in SIZE_W: frame dimensions, latched on accepted `start`
- `hblank` in BLANK_W: idle cycles inserted after every non-final line, latched on `start`
- `src_pixel` in DW, `src_valid` in 1, `src_ready` out 1: source handshake
- `pixel_out` out DW, `out_valid` out 1, `out_ready` in 1: DUT-side handshake
- `sof`, `eol`, `eof` out 1: markers, qualified by `out_valid`
- `busy` out 1: state != IDLE
- `done` out 1: one-cycle completion pulse
- `frame_count` out 16: completed frames, wraps at 65535 -> 0

## Operation
- States: IDLE, RUNNING, BLANK, DONE (`t_feeder_states`).
- IDLE: `start`=1 latches the sizes and `hblank`, clears `x`/`y`, and enters RUNNING. If `size_x`==0 or `size_y`==0, it goes to DONE instead.
- RUNNING: `src_ready = !out_valid || out_ready`.
  - A transfer is `src_valid && src_ready`.
  - Each transfer loads the output register with the pixel plus flags: `sof` = (x==0 && y==0); `eol` = (x==size_x-1); `eof` = eol && (y==size_y-1).
  - x increments. At eol, x clears and y increments.
  - After an eof transfer: go to DONE.
  - After a non-final eol transfer: go to BLANK if `hblank`>0, else stay in RUNNING.
- BLANK: `src_ready`=0. A down-counter loaded with `hblank` decrements each cycle; on reaching 1, return to RUNNING. Exactly `hblank` cycles are spent in BLANK.
- DONE: `src_ready`=0. When `!out_valid || out_ready`, go to IDLE and register `done`=1 and `frame_count`+1.
- Output register: clears `out_valid` on `out_ready` when no new transfer occurs. Data and flags are held stable while `out_valid && !out_ready`.
- `abort` (any state): next cycle state=IDLE, `out_valid`=0, counters cleared, no `done`, `frame_count` unchanged. `abort` has priority over `start`.
- `start` outside IDLE is ignored.
- Arithmetic: x and y are SIZE_W wide. Comparisons use the latched `size-1`, so the maximum size `2^SIZE_W-1` works without overflow.

## Timing
- Reset values: state IDLE, `src_ready`=0, `out_valid`=0, `pixel_out`=0, `sof`/`eol`/`eof`=0, `busy`=0, `done`=0, `frame_count`=0.
- `start` at cycle 0 -> `busy`=1 and `src_ready`=1 (if no output is pending) at cycle 1.
- Latency: a transfer at cycle n gives `out_valid` with that pixel at cycle n+1.
- Throughput: 1 pixel/cycle with `out_ready` held at 1. `out_ready`=0 stalls the source in the same cycle via `src_ready`.
- `done` is high in the first IDLE cycle after the last output handshake. A new `start` is accepted in that same cycle.
- Zero-size frame: `start` at cycle 0 -> DONE at cycle 1 -> `done` at cycle 2, with no `out_valid`.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous assertion).

## Structure
- `pixel_pkg`: `t_feeder_states` enum, `t_pixel_flags` struct {sof, eol, eof}, and the `FRAME_CNT_W`=16 constant.
- Sub-module `pixel_raster_counter`:
  - contains the x/y counters and the size compare;
  - inputs: `clr`, `adv`, latched sizes;
  - outputs: `x`, `y`, `last_x`, `last_y`.
- The top level holds the FSM, blank counter, output register and frame counter.

## Test plan
- 4x3 frame, `hblank`=0, `out_ready`=1, `src_valid`=1 -> 12 pixels on consecutive cycles; `sof` on pixel 0; `eol` on pixels 3, 7, 11; `eof` on pixel 11; `done` 1 cycle after the last output; `frame_count`=1.
- 4x3 frame, `hblank`=2 -> exactly 2 `src_ready`=0 cycles after pixels 3 and 7, none after 11; total 16 cycles from first to last transfer.
- Random `out_ready` (50%) and `src_valid` gaps on a 5x5 frame -> output sequence equals the input sequence 0..24; data held stable while stalled; no drops or duplicates.
- `size_x`=0, `start` -> no `out_valid`; `done` at cycle 2; `frame_count` increments.
- `abort` after pixel 5 of 8x8 -> `out_valid`=0 and IDLE next cycle; no `done`; a following 2x2 frame starts with `sof`=1 at x=0, y=0.
- Assert `rst`=0 mid-frame, release, run a 2x2 frame -> all outputs at reset values while in reset; `frame_count` restarts at 1 after the frame.
